// File: rtl/snn_pkg.sv
// Shared state encoding and frame constants for the digit-recognition sequencer.
package snn_pkg;

  typedef enum logic [2:0] {
    LOAD,
    WRITE,
    START,
    WAIT_CORE,
    SEND,
    WAIT_TX
  } state_t;

  localparam int         IMG_BYTES  = 98;
  localparam int         IMG_BITS   = IMG_BYTES * 8;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Raw digits go out as a plain binary nibble; ASCII mode adds '0' for terminals.
  function automatic logic [7:0] digit_to_tx(input logic [3:0] digit, input logic ascii);
    logic [7:0] raw;
    raw = {4'h0, digit};
    return ascii ? (ASCII_ZERO + raw) : raw;
  endfunction

endpackage

// File: rtl/snn_ctrl_byte_serializer.sv
// Turns one received byte into eight LSB-first pixel bits for the input-unit RAM loader.
module byte_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       shift,
  output logic       bit_out,
  output logic       last
);

  logic [7:0] shreg;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= 3'd0;
    end else if (shift) begin
      shreg   <= {1'b0, shreg[7:1]};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign bit_out = shreg[0];
  // High during the cycle that emits the eighth bit of the byte.
  assign last    = shift && (bit_cnt == 3'd7);

endmodule

// File: rtl/snn_ctrl.sv
// Image loader / core sequencer / result sender for the SNN digit path.
// Define SNN_CTRL_ASCII_OUT_EN to transmit the digit as ASCII '0'..'9' instead of raw binary.
module snn_ctrl #(
  parameter int IMG_BYTES = snn_pkg::IMG_BYTES,
  parameter int ADDR_W    = $clog2(snn_pkg::IMG_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              ram_we,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              overrun
);

  import snn_pkg::*;

  localparam int             BCW       = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(IMG_BYTES - 1);

`ifdef SNN_CTRL_ASCII_OUT_EN
  localparam logic ASCII_OUT = 1'b1;
`else
  localparam logic ASCII_OUT = 1'b0;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [BCW-1:0]    byte_cnt;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        tx_reg;
  logic              accept;
  logic              writing;
  logic              ser_bit;
  logic              ser_last;

  assign accept  = rx_rdy && (state == LOAD);
  assign writing = (state == WRITE);

  byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .din     (rx_data),
    .shift   (writing),
    .bit_out (ser_bit),
    .last    (ser_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:      if (rx_rdy) state_nxt = WRITE;
      WRITE:     if (ser_last) state_nxt = (byte_cnt == LAST_BYTE) ? START : LOAD;
      START:     state_nxt = WAIT_CORE;
      WAIT_CORE: if (core_done) state_nxt = SEND;
      SEND:      state_nxt = WAIT_TX;
      WAIT_TX:   if (tx_done) state_nxt = LOAD;
      default:   state_nxt = LOAD;
    endcase
  end

  // The transmit byte is captured with the digit so it stays stable until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      load_addr <= '0;
      tx_reg    <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      if (writing) begin
        load_addr <= load_addr + ADDR_W'(1);
        if (ser_last && (byte_cnt != LAST_BYTE)) byte_cnt <= byte_cnt + BCW'(1);
      end
      if ((state == WAIT_CORE) && core_done) tx_reg <= digit_to_tx(core_digit, ASCII_OUT);
      if ((state == WAIT_TX) && tx_done) begin
        byte_cnt  <= '0;
        load_addr <= '0;
      end
      if (rx_rdy && (state != LOAD)) overrun <= 1'b1;
    end
  end

  always_comb begin
    ram_addr   = load_addr;
    ram_data   = 1'b0;
    ram_we     = 1'b0;
    core_start = 1'b0;
    tx_start   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      WRITE: begin
        ram_we   = 1'b1;
        ram_data = ser_bit;
      end
      START: begin
        ram_addr   = core_addr;
        core_start = 1'b1;
        busy       = 1'b1;
      end
      WAIT_CORE: begin
        ram_addr = core_addr;
        busy     = 1'b1;
      end
      SEND: begin
        tx_start = 1'b1;
        busy     = 1'b1;
      end
      WAIT_TX: busy = 1'b1;
      default: ;
    endcase
  end

  assign tx_data = tx_reg;

endmodule

// File: tb/tb_snn_ctrl.sv
// Scoreboard bench for snn_ctrl: random frames checked against a pixel-level reference model.
module tb_snn_ctrl;

  localparam int IMG_BYTES = 98;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_rdy = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              core_start;
  logic              core_done = 1'b0;
  logic [3:0]        core_digit = 4'h0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              ram_we;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done = 1'b0;
  logic              busy;
  logic              overrun;

  snn_ctrl #(.IMG_BYTES(IMG_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .core_addr  (core_addr),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; int data; } tx_t;

  wr_t wr_q[$];
  int  start_q[$];
  tx_t tx_q[$];

  int compared   = 0;
  int mismatched = 0;
  bit mon_en     = 1'b0;
  int next_addr  = 0;
  int last_rx    = 0;

  function automatic int expTx(input int digit);
`ifdef SNN_CTRL_ASCII_OUT_EN
    return 48 + digit;
`else
    return digit;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One rx_rdy pulse; an accepted byte becomes eight pixel writes, pixel i from bit i.
  task automatic applyStimulus(input logic [7:0] b, input bit accept);
    wr_t e;
    int  n;
    n       = cyc;
    rx_rdy  = 1'b1;
    rx_data = b;
    if (accept) begin
      for (int i = 0; i < 8; i++) begin
        e.cyc  = n + 1 + i;
        e.addr = next_addr + i;
        e.data = int'(b[i]);
        wr_q.push_back(e);
      end
      next_addr += 8;
      last_rx = n;
    end
    tick(1);
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic resetDut();
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ram_we",     ram_we,     0);
    checkOutput("rst_ram_addr",   ram_addr,   0);
    checkOutput("rst_ram_data",   ram_data,   0);
    checkOutput("rst_core_start", core_start, 0);
    checkOutput("rst_tx_start",   tx_start,   0);
    checkOutput("rst_tx_data",    tx_data,    0);
    checkOutput("rst_busy",       busy,       0);
    checkOutput("rst_overrun",    overrun,    0);
    wr_q.delete();
    start_q.delete();
    tx_q.delete();
    rx_rdy    = 1'b0;
    core_done = 1'b0;
    tx_done   = 1'b0;
    core_addr = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    mon_en = 1'b1;
  endtask

  // fill < 0 means random bytes; gap == 0 means random spacing of 9..20 cycles.
  task automatic runFrame(input int first, input int fill, input int gap, input int digit,
                          input bit drops, input bit combo, input int abort_at);
    logic [7:0] b;
    tx_t        t;
    int         g;
    next_addr  = 0;
    core_done  = 1'b1;
    tx_done    = 1'b1;
    core_digit = 4'hE;
    tick(1);
    core_done = 1'b0;
    tx_done   = 1'b0;
    for (int k = 0; k < IMG_BYTES; k++) begin
      if (k == 0 && first >= 0) b = 8'(first);
      else if (fill >= 0)       b = 8'(fill);
      else                      b = 8'($urandom);
      applyStimulus(b, 1'b1);
      if (k == abort_at) begin
        tick(3);
        resetDut();
        return;
      end
      if (k == IMG_BYTES - 1) break;
      g = (gap > 0) ? gap : int'($urandom_range(9, 20));
      if (drops && k == 5) begin
        tick(2);
        applyStimulus(8'h3C, 1'b0);
        checkOutput("overrun_write", overrun, 1);
        tick(g - 4);
      end else begin
        tick(g - 1);
      end
    end
    start_q.push_back(last_rx + 9);
    tick(9);
    core_addr = 10'h123;
    #1;
    checkOutput("mux_addr",       ram_addr, 'h123);
    checkOutput("mux_we",         ram_we,   0);
    checkOutput("busy_wait_core", busy,     1);
    if (drops) begin
      applyStimulus(8'hC3, 1'b0);
      checkOutput("overrun_wait_core", overrun, 1);
    end else begin
      tick(1);
    end
    core_done  = 1'b1;
    core_digit = 4'(digit);
    t.cyc  = cyc + 1;
    t.data = expTx(digit);
    tx_q.push_back(t);
    tick(1);
    core_done  = 1'b0;
    core_digit = 4'($urandom);
    core_addr  = 10'($urandom);
    tick(3);
    checkOutput("busy_wait_tx", busy, 1);
    tx_done = 1'b1;
    if (combo) begin
      rx_rdy  = 1'b1;
      rx_data = 8'h99;
    end
    tick(1);
    tx_done = 1'b0;
    rx_rdy  = 1'b0;
    checkOutput("busy_idle", busy,    0);
    checkOutput("tx_hold",   tx_data, expTx(digit));
    if (combo) checkOutput("overrun_combo", overrun, 1);
    tick(2);
  endtask

  // Monitor: every DUT-presented event must match the head of its scoreboard queue.
  always @(negedge clk) begin
    wr_t e;
    tx_t t;
    int  s;
    if (mon_en && rst_n) begin
      if (ram_we) begin
        if (wr_q.size() == 0) checkOutput("extra_write", int'(ram_addr), -1);
        else begin
          e = wr_q.pop_front();
          checkOutput("wr_cycle", cyc,           e.cyc);
          checkOutput("wr_addr",  int'(ram_addr), e.addr);
          checkOutput("wr_data",  int'(ram_data), e.data);
        end
      end
      if (core_start) begin
        if (start_q.size() == 0) checkOutput("extra_core_start", cyc, -1);
        else begin
          s = start_q.pop_front();
          checkOutput("start_cycle", cyc,  s);
          checkOutput("start_busy",  busy, 1);
        end
      end
      if (tx_start) begin
        if (tx_q.size() == 0) checkOutput("extra_tx_start", cyc, -1);
        else begin
          t = tx_q.pop_front();
          checkOutput("tx_cycle", cyc,           t.cyc);
          checkOutput("tx_data",  int'(tx_data), t.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    tick(2);
    resetDut();
    $display("[TB] frame A: all 0xFF, 20-cycle spacing, digit 7");
    runFrame(-1, 8'hFF, 20, 7, 1'b0, 1'b0, -1);
    checkOutput("overrun_clean", overrun, 0);
    $display("[TB] frame B: first byte 0xA5, digit 3, rx with tx_done");
    runFrame(8'hA5, -1, 0, 3, 1'b0, 1'b1, -1);
    $display("[TB] frame C: drops in WRITE and WAIT_CORE, digit 9");
    runFrame(-1, -1, 9, 9, 1'b1, 1'b0, -1);
    checkOutput("overrun_sticky", overrun, 1);
    $display("[TB] frame D: reset during byte 40");
    runFrame(-1, -1, 0, 5, 1'b0, 1'b0, 40);
    $display("[TB] frame E: fresh frame after reset");
    runFrame(-1, -1, 0, int'($urandom_range(0, 9)), 1'b0, 1'b0, -1);
    checkOutput("overrun_after_reset", overrun, 0);
    tick(5);
    checkOutput("writes_left", wr_q.size(),    0);
    checkOutput("starts_left", start_q.size(), 0);
    checkOutput("tx_left",     tx_q.size(),    0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
